fft_frame_scheduler: RTL and testbench
======================================

# fft_frame_scheduler

Sequences overlapped analysis frames out of the 16-bit audio sample ring buffer into the FFT input stage. It tracks the ring write pointer and fires a frame every HOP samples once FRAME_LEN samples exist. It then issues FRAME_LEN/2 read-address pairs (x[k], x[k+FRAME_LEN/2]) to the first butterfly stage over a valid/ready handshake. It sits between the I2S receive path (sample strobe, buffer write) and the FFT core, all in the mclk domain.

## Interface
- AW, 7: ring address width; depth 2^AW. Constraint: 2^AW >= FRAME_LEN + 2*HOP.
- FRAME_LEN, 32: samples per frame; power of two, >= 4.
- HOP, 12: new samples between frame starts; 1 <= HOP <= FRAME_LEN.
- mclk  in  1  clock, 12.288 MHz, rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- enable  in  1  run control; low = sample_en ignored.
- sample_en  in  1  one-cycle pulse; a sample is written at wr_ptr this cycle.
- wr_ptr  out  AW  ring write address for the current sample.
- rd_addr_pre  out  AW  address of x[k].
- rd_addr_next  out  AW  address of x[k+FRAME_LEN/2].
- pair_valid  out  1  address pair valid.
- pair_ready  in  1  FFT accepts pair.
- pair_first  out  1  qualifies k==0.
- pair_last  out  1  qualifies k==FRAME_LEN/2-1.
- busy  out  1  high in ISSUE.
- overrun_cnt  out  8  frames dropped; saturates at 255.

## Operation
- Accepted sample: sample_en & enable.
- wr_ptr: increments mod 2^AW per accepted sample.
- fill: counts accepted samples and saturates at FRAME_LEN.
- hop_cnt: 0..HOP-1, counts accepted samples.
- Trigger: an accepted sample with hop_cnt==HOP-1 (hop_cnt then wraps to 0) and post-increment fill == FRAME_LEN.
  - Frame base = wr_ptr - FRAME_LEN + 1 (mod 2^AW), i.e. the oldest sample, with the newest at the current wr_ptr.
- States:
  - IDLE: pair_valid=0.
    - Trigger -> ISSUE with k=0 and base latched.
  - ISSUE: pair_valid=1; rd_addr_pre=base+k, rd_addr_next=base+k+FRAME_LEN/2, both mod 2^AW.
    - On pair_valid&pair_ready: k++.
    - On the accepting cycle with k==FRAME_LEN/2-1: if a frame is pending, reload base from it, clear pending, and set k=0 (stay in ISSUE). Otherwise go to IDLE.
- Pending slot (one deep):
  - Trigger in ISSUE: store base and set pending.
  - Trigger while pending is already set: overwrite with the newest base and increment overrun_cnt (saturating). The oldest frame is dropped.
  - Trigger on the same cycle as final-pair acceptance: it becomes the next frame; no overrun.
- enable low:
  - Clears fill, hop_cnt, and pending.
  - wr_ptr holds.
  - A frame in ISSUE runs to completion, then goes to IDLE.
  - overrun_cnt holds.
- pair_first/pair_last are combinational from k and state, and are low when pair_valid=0.

## Timing
- Reset values: state IDLE, wr_ptr=0, rd_addr_pre=0, rd_addr_next=0, pair_valid=0, pair_first=0, pair_last=0, busy=0, overrun_cnt=0; fill, hop_cnt, k, pending all 0.
- Registered outputs except pair_first/pair_last.
- Trigger sample at cycle N -> pair_valid=1 with k=0 addresses at N+1.
- wr_ptr updates at N+1 after an accepted sample at N.
- Full-rate handshake: one pair per cycle; frame length FRAME_LEN/2 cycles with ready held high.
- Back-to-back frames: no bubble between last pair of frame A and first pair of pending frame B.
- Backpressure: while pair_valid & !pair_ready, addresses and flags are held stable. pair_valid never drops before acceptance.
- Reset asserted mid-frame: outputs go to reset values immediately (async); the frame is abandoned.

## Test plan
- Reset, enable=1, 36 sample_en pulses spaced 8 cycles, ready=1.
  - No pairs after samples 12 and 24 (fill<32).
  - After sample 36: 16 pairs (4,20)..(19,35).
  - pair_first on the first pair, pair_last on the 16th.
- Same as above, but pair_ready toggles 1-0-0-1.
  - Addresses stable while stalled.
  - Exactly 16 acceptances.
  - overrun_cnt=0.
- Hold pair_ready=0 from first frame through triggers at samples 48 and 60.
  - overrun_cnt=1.
  - After release: frame at base 4 completes, then base 28 (pairs (28,44)..), with no frame at base 16.
- Run to the trigger at sample 132 (wr_ptr=3).
  - base=100.
  - First pair (100,116), last pair (115,3): wrap-around correct.
- Drop enable during pair k=5.
  - Frame completes all 16 pairs, then IDLE.
  - Re-enable: next frame only after 32 new samples and on a hop boundary.
- Assert rst at pair k=7.
  - pair_valid=0, wr_ptr=0, overrun_cnt=0 without a clock edge.
  - Release: behaves as the first test.

Source files
------------

// File: rtl/fft_frame_scheduler.sv
// Schedules overlapped FFT analysis frames out of the audio sample ring buffer
// and streams the first-stage butterfly read-address pairs over valid/ready.
module fft_frame_scheduler #(
    parameter int unsigned AW        = 7,
    parameter int unsigned FRAME_LEN = 32,
    parameter int unsigned HOP       = 12
) (
    input  logic          i_mclk,
    input  logic          i_rst_n,
    input  logic          i_enable,
    input  logic          i_sample_en,
    output logic [AW-1:0] o_wr_ptr,
    output logic [AW-1:0] o_rd_addr_pre,
    output logic [AW-1:0] o_rd_addr_next,
    output logic          o_pair_valid,
    input  logic          i_pair_ready,
    output logic          o_pair_first,
    output logic          o_pair_last,
    output logic          o_busy,
    output logic [7:0]    o_overrun_cnt
);

    localparam int unsigned HALF = FRAME_LEN / 2;
    localparam int unsigned KW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int unsigned FW   = $clog2(FRAME_LEN + 1);
    localparam int unsigned HW   = (HOP > 1) ? $clog2(HOP) : 1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [AW-1:0] r_wr_ptr;
    logic [FW-1:0] r_fill;
    logic [HW-1:0] r_hop_cnt;
    logic [KW-1:0] r_k, w_k_nxt;
    logic [AW-1:0] r_base, w_base_nxt;
    logic          r_pend, w_pend_nxt;
    logic [AW-1:0] r_pend_base, w_pend_base_nxt;
    logic [7:0]    r_overrun, w_overrun_nxt;
    logic [AW-1:0] r_rd_pre, r_rd_next;

    logic          w_accept;
    logic [FW-1:0] w_fill_inc;
    logic          w_trig;
    logic [AW-1:0] w_trig_base;
    logic          w_pair_acc;
    logic          w_done;
    logic          w_pend_eff;

    assign w_accept    = i_sample_en & i_enable;
    assign w_fill_inc  = (r_fill == FW'(FRAME_LEN)) ? r_fill : r_fill + FW'(1);
    assign w_trig      = w_accept && (r_hop_cnt == HW'(HOP - 1)) && (w_fill_inc == FW'(FRAME_LEN));
    assign w_trig_base = r_wr_ptr - AW'(FRAME_LEN - 1);
    assign w_pair_acc  = (r_state == S_ISSUE) && i_pair_ready;
    assign w_done      = w_pair_acc && (r_k == KW'(HALF - 1));
    // A disabled block forgets any queued frame, so it never chains into it.
    assign w_pend_eff  = r_pend & i_enable;

    // Sample-side bookkeeping: write pointer, fill level, hop phase.
    always_ff @(posedge i_mclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr  <= '0;
            r_fill    <= '0;
            r_hop_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (!i_enable) begin
                r_fill    <= '0;
                r_hop_cnt <= '0;
            end else if (w_accept) begin
                r_fill    <= w_fill_inc;
                r_hop_cnt <= (r_hop_cnt == HW'(HOP - 1)) ? '0 : r_hop_cnt + HW'(1);
            end
        end
    end

    // State register plus registered address outputs.
    always_ff @(posedge i_mclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_k         <= '0;
            r_base      <= '0;
            r_pend      <= 1'b0;
            r_pend_base <= '0;
            r_overrun   <= '0;
            r_rd_pre    <= '0;
            r_rd_next   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_k         <= w_k_nxt;
            r_base      <= w_base_nxt;
            r_pend      <= w_pend_nxt;
            r_pend_base <= w_pend_base_nxt;
            r_overrun   <= w_overrun_nxt;
            if (w_state_nxt == S_ISSUE) begin
                r_rd_pre  <= w_base_nxt + AW'(w_k_nxt);
                r_rd_next <= w_base_nxt + AW'(w_k_nxt) + AW'(HALF);
            end
        end
    end

    // Next-state: frame launch, pair advance, pending slot and overrun tracking.
    always_comb begin
        w_state_nxt     = r_state;
        w_k_nxt         = r_k;
        w_base_nxt      = r_base;
        w_pend_nxt      = w_pend_eff;
        w_pend_base_nxt = r_pend_base;
        w_overrun_nxt   = r_overrun;
        case (r_state)
            S_IDLE: begin
                if (w_trig) begin
                    w_state_nxt = S_ISSUE;
                    w_k_nxt     = '0;
                    w_base_nxt  = w_trig_base;
                end
            end
            S_ISSUE: begin
                if (w_pair_acc) begin
                    w_k_nxt = r_k + KW'(1);
                end
                if (w_done) begin
                    w_k_nxt = '0;
                    if (w_pend_eff) begin
                        // Slot drains into the next frame; a same-cycle trigger refills it.
                        w_base_nxt = r_pend_base;
                        w_pend_nxt = w_trig;
                        if (w_trig) begin
                            w_pend_base_nxt = w_trig_base;
                        end
                    end else if (w_trig) begin
                        w_base_nxt = w_trig_base;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (w_trig) begin
                    if (w_pend_eff && (r_overrun != 8'hFF)) begin
                        w_overrun_nxt = r_overrun + 8'd1;
                    end
                    w_pend_nxt      = 1'b1;
                    w_pend_base_nxt = w_trig_base;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign o_wr_ptr       = r_wr_ptr;
    assign o_rd_addr_pre  = r_rd_pre;
    assign o_rd_addr_next = r_rd_next;
    assign o_pair_valid   = (r_state == S_ISSUE);
    assign o_busy         = (r_state == S_ISSUE);
    assign o_overrun_cnt  = r_overrun;
    assign o_pair_first   = (r_state == S_ISSUE) && (r_k == KW'(0));
    assign o_pair_last    = (r_state == S_ISSUE) && (r_k == KW'(HALF - 1));

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Directed bench for fft_frame_scheduler: frame timing, backpressure, overrun,
// ring wrap, enable drop and mid-frame reset.
module tb_fft_frame_scheduler;

    localparam int unsigned AW    = 7;
    localparam int          DEPTH = 128;
    localparam int          HALF  = 16;

    logic          clk;
    logic          i_rst_n;
    logic          i_enable;
    logic          i_sample_en;
    logic          i_pair_ready;
    logic [AW-1:0] o_wr_ptr;
    logic [AW-1:0] o_rd_addr_pre;
    logic [AW-1:0] o_rd_addr_next;
    logic          o_pair_valid;
    logic          o_pair_first;
    logic          o_pair_last;
    logic          o_busy;
    logic [7:0]    o_overrun_cnt;

    int n_vec;
    int n_err;
    int ready_mode;
    int cyc;
    bit prev_stall;
    logic [31:0] held_pre, held_next, held_first;
    logic [31:0] q_pre[$];
    logic [31:0] q_next[$];
    logic [31:0] q_first[$];
    logic [31:0] q_last[$];

    fft_frame_scheduler #(.AW(7), .FRAME_LEN(32), .HOP(12)) dut (
        .i_mclk        (clk),
        .i_rst_n       (i_rst_n),
        .i_enable      (i_enable),
        .i_sample_en   (i_sample_en),
        .o_wr_ptr      (o_wr_ptr),
        .o_rd_addr_pre (o_rd_addr_pre),
        .o_rd_addr_next(o_rd_addr_next),
        .o_pair_valid  (o_pair_valid),
        .i_pair_ready  (i_pair_ready),
        .o_pair_first  (o_pair_first),
        .o_pair_last   (o_pair_last),
        .o_busy        (o_busy),
        .o_overrun_cnt (o_overrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, act, exp);
        end
    endtask

    // One cycle: drive inputs at the falling edge and log pairs the rising edge will accept.
    task automatic tick(input bit se);
        @(negedge clk);
        if (prev_stall) begin
            chk("hold_valid", 32'(o_pair_valid), 32'd1);
            chk("hold_pre",   32'(o_rd_addr_pre), held_pre);
            chk("hold_next",  32'(o_rd_addr_next), held_next);
            chk("hold_first", 32'(o_pair_first), held_first);
        end
        i_sample_en = se;
        case (ready_mode)
            0:       i_pair_ready = 1'b1;
            1:       i_pair_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: i_pair_ready = 1'b0;
        endcase
        cyc++;
        if (o_pair_valid && i_pair_ready) begin
            q_pre.push_back(32'(o_rd_addr_pre));
            q_next.push_back(32'(o_rd_addr_next));
            q_first.push_back(32'(o_pair_first));
            q_last.push_back(32'(o_pair_last));
        end
        prev_stall = o_pair_valid && !i_pair_ready;
        held_pre   = 32'(o_rd_addr_pre);
        held_next  = 32'(o_rd_addr_next);
        held_first = 32'(o_pair_first);
    endtask

    task automatic run_samples(input int n);
        repeat (n) begin
            tick(1'b1);
            repeat (7) tick(1'b0);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0);
    endtask

    task automatic clear_log();
        q_pre.delete();
        q_next.delete();
        q_first.delete();
        q_last.delete();
    endtask

    task automatic check_frame(input string tag, input int start, input int base);
        for (int i = 0; i < HALF; i++) begin
            if (start + i < q_pre.size()) begin
                chk({tag, "_pre"},   q_pre[start+i],   32'((base + i) % DEPTH));
                chk({tag, "_next"},  q_next[start+i],  32'((base + HALF + i) % DEPTH));
                chk({tag, "_first"}, q_first[start+i], 32'(i == 0));
                chk({tag, "_last"},  q_last[start+i],  32'(i == HALF - 1));
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_rst_n      = 1'b0;
        i_enable     = 1'b1;
        i_sample_en  = 1'b0;
        i_pair_ready = 1'b1;
        prev_stall   = 1'b0;
        clear_log();
        @(negedge clk);
        i_rst_n = 1'b1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        cyc = 0;
        ready_mode = 0;
        prev_stall = 1'b0;
        i_rst_n = 1'b0;
        i_enable = 1'b0;
        i_sample_en = 1'b0;
        i_pair_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_wr_ptr",  32'(o_wr_ptr), 32'd0);
        chk("rst_valid",   32'(o_pair_valid), 32'd0);
        chk("rst_first",   32'(o_pair_first), 32'd0);
        chk("rst_last",    32'(o_pair_last), 32'd0);
        chk("rst_busy",    32'(o_busy), 32'd0);
        chk("rst_overrun", 32'(o_overrun_cnt), 32'd0);
        chk("rst_pre",     32'(o_rd_addr_pre), 32'd0);
        chk("rst_next",    32'(o_rd_addr_next), 32'd0);

        // Basic frame: first frame only at sample 36, base 4
        do_reset();
        ready_mode = 0;
        run_samples(35);
        chk("t1_no_early", 32'(q_pre.size()), 32'd0);
        tick(1'b1);
        @(posedge clk);
        #1;
        chk("t1_lat_valid", 32'(o_pair_valid), 32'd1);
        chk("t1_lat_pre",   32'(o_rd_addr_pre), 32'd4);
        chk("t1_lat_next",  32'(o_rd_addr_next), 32'd20);
        chk("t1_lat_first", 32'(o_pair_first), 32'd1);
        chk("t1_wr_ptr",    32'(o_wr_ptr), 32'd36);
        idle(20);
        chk("t1_count", 32'(q_pre.size()), 32'd16);
        check_frame("t1", 0, 4);
        chk("t1_idle_valid", 32'(o_pair_valid), 32'd0);
        chk("t1_idle_busy",  32'(o_busy), 32'd0);

        // Toggling ready 1-0-0-1
        do_reset();
        ready_mode = 1;
        run_samples(36);
        idle(50);
        chk("t2_count", 32'(q_pre.size()), 32'd16);
        check_frame("t2", 0, 4);
        chk("t2_overrun", 32'(o_overrun_cnt), 32'd0);
        chk("t2_valid",   32'(o_pair_valid), 32'd0);

        // Stall through triggers at 48 and 60: base 16 dropped
        do_reset();
        ready_mode = 2;
        run_samples(60);
        chk("t3_overrun", 32'(o_overrun_cnt), 32'd1);
        chk("t3_valid",   32'(o_pair_valid), 32'd1);
        chk("t3_pre",     32'(o_rd_addr_pre), 32'd4);
        ready_mode = 0;
        idle(40);
        chk("t3_count", 32'(q_pre.size()), 32'd32);
        check_frame("t3a", 0, 4);
        check_frame("t3b", 16, 28);
        chk("t3_overrun2", 32'(o_overrun_cnt), 32'd1);
        chk("t3_idle",     32'(o_pair_valid), 32'd0);

        // Async reset at k=7 of the frame triggered at sample 72 (base 40)
        clear_log();
        run_samples(11);
        tick(1'b1);
        repeat (7) tick(1'b0);
        @(negedge clk);
        chk("t6_pre_k7",   32'(o_rd_addr_pre), 32'd47);
        chk("t6_valid_k7", 32'(o_pair_valid), 32'd1);
        i_rst_n = 1'b0;
        #1;
        chk("t6_valid",   32'(o_pair_valid), 32'd0);
        chk("t6_wr_ptr",  32'(o_wr_ptr), 32'd0);
        chk("t6_overrun", 32'(o_overrun_cnt), 32'd0);
        chk("t6_first",   32'(o_pair_first), 32'd0);
        chk("t6_busy",    32'(o_busy), 32'd0);
        chk("t6_pre",     32'(o_rd_addr_pre), 32'd0);
        chk("t6_next",    32'(o_rd_addr_next), 32'd0);
        @(negedge clk);
        i_rst_n = 1'b1;
        prev_stall = 1'b0;
        clear_log();
        run_samples(36);
        idle(20);
        chk("t6_count", 32'(q_pre.size()), 32'd16);
        check_frame("t6", 0, 4);

        // Ring wrap: trigger at sample 132, base 100
        do_reset();
        ready_mode = 0;
        run_samples(131);
        clear_log();
        tick(1'b1);
        idle(20);
        chk("t4_count",  32'(q_pre.size()), 32'd16);
        check_frame("t4", 0, 100);
        chk("t4_wr_ptr", 32'(o_wr_ptr), 32'd4);

        // Enable dropped at k=5
        do_reset();
        ready_mode = 0;
        run_samples(35);
        tick(1'b1);
        repeat (6) tick(1'b0);
        chk("t5_pre_k5", 32'(o_rd_addr_pre), 32'd9);
        i_enable = 1'b0;
        idle(20);
        run_samples(3);
        chk("t5_count",   32'(q_pre.size()), 32'd16);
        check_frame("t5", 0, 4);
        chk("t5_valid",   32'(o_pair_valid), 32'd0);
        chk("t5_busy",    32'(o_busy), 32'd0);
        chk("t5_wr_hold", 32'(o_wr_ptr), 32'd36);
        i_enable = 1'b1;
        clear_log();
        run_samples(35);
        chk("t5_no_early", 32'(q_pre.size()), 32'd0);
        run_samples(1);
        idle(20);
        chk("t5_count2", 32'(q_pre.size()), 32'd16);
        check_frame("t5b", 0, 40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
